matrix_operand_serializer: RTL

Transmit end of the bit-serial operand interface consumed by matrix_multiplier. Accepts one pair of N x N matrices (A, B) of W-bit unsigned elements as parallel words through a valid/ready handshake. Emits a one-cycle start pulse, then streams both matrices bit-serially and in lock-step on the A and B lines. A one-deep pending buffer lets the next operand pair be accepted while the current frame is still shifting.

---
 rtl/matrix_operand_serializer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/matrix_operand_serializer.sv
// Serial transmit side of the matrix operand link: accepts an (A, B) matrix pair
// through valid/ready, then sends start followed by both matrices LSB-first in lock-step.
module matrix_operand_serializer #(
    parameter int N   = 2,
    parameter int W   = 8,
    parameter int GAP = 2
) (
    input  logic             clk,
    input  logic             NRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*N*W-1:0] a_flat,
    input  logic [N*N*W-1:0] b_flat,
    output logic             start,
    output logic             A,
    output logic             B,
    output logic             busy,
    output logic             frame_done
);

    localparam int NB    = N * N * W;
    localparam int CMAX  = (NB > GAP) ? NB : GAP;
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(NB - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_pend_valid;
    logic             w_pend_valid_nxt;
    logic [NB-1:0]    r_a_p;
    logic [NB-1:0]    r_b_p;
    logic [NB-1:0]    w_a_p_nxt;
    logic [NB-1:0]    w_b_p_nxt;
    logic [NB-1:0]    r_a_sr;
    logic [NB-1:0]    r_b_sr;
    logic [NB-1:0]    w_a_sr_nxt;
    logic [NB-1:0]    w_b_sr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_start;
    logic             r_a;
    logic             r_b;
    logic             r_busy;
    logic             r_done;
    logic             w_start_nxt;
    logic             w_a_nxt;
    logic             w_b_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_xfer;

    assign in_ready   = ~r_pend_valid;
    assign w_xfer     = in_valid & ~r_pend_valid;
    assign start      = r_start;
    assign A          = r_a;
    assign B          = r_b;
    assign busy       = r_busy;
    assign frame_done = r_done;

    // Next-state, pending-buffer and output-flop next values
    always_comb begin
        w_state_nxt      = r_state;
        w_pend_valid_nxt = r_pend_valid;
        w_a_p_nxt        = r_a_p;
        w_b_p_nxt        = r_b_p;
        w_a_sr_nxt       = r_a_sr;
        w_b_sr_nxt       = r_b_sr;
        w_cnt_nxt        = r_cnt;
        w_a_nxt          = 1'b0;
        w_b_nxt          = 1'b0;
        w_done_nxt       = 1'b0;

        // While a frame is running, an accepted pair parks in the pending buffer
        if (w_xfer && (r_state != S_IDLE)) begin
            w_pend_valid_nxt = 1'b1;
            w_a_p_nxt        = a_flat;
            w_b_p_nxt        = b_flat;
        end else begin
            w_pend_valid_nxt = r_pend_valid;
        end

        case (r_state)
            S_IDLE: begin
                if (r_pend_valid) begin
                    w_a_sr_nxt       = r_a_p;
                    w_b_sr_nxt       = r_b_p;
                    w_pend_valid_nxt = 1'b0;
                    w_state_nxt      = S_START;
                end else if (w_xfer) begin
                    w_a_sr_nxt  = a_flat;
                    w_b_sr_nxt  = b_flat;
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                // The output flop runs one bit behind the shift register
                w_cnt_nxt   = {CNT_W{1'b0}};
                w_a_nxt     = r_a_sr[0];
                w_b_nxt     = r_b_sr[0];
                w_a_sr_nxt  = r_a_sr >> 1;
                w_b_sr_nxt  = r_b_sr >> 1;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == BIT_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = (GAP == 0) ? S_IDLE : S_GAP;
                end else begin
                    w_a_nxt     = r_a_sr[0];
                    w_b_nxt     = r_b_sr[0];
                    w_a_sr_nxt  = r_a_sr >> 1;
                    w_b_sr_nxt  = r_b_sr >> 1;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = S_GAP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_start_nxt = (w_state_nxt == S_START);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    // State, buffers and registered outputs
    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            r_state      <= S_IDLE;
            r_pend_valid <= 1'b0;
            r_a_p        <= {NB{1'b0}};
            r_b_p        <= {NB{1'b0}};
            r_a_sr       <= {NB{1'b0}};
            r_b_sr       <= {NB{1'b0}};
            r_cnt        <= {CNT_W{1'b0}};
            r_start      <= 1'b0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_a_p        <= w_a_p_nxt;
            r_b_p        <= w_b_p_nxt;
            r_a_sr       <= w_a_sr_nxt;
            r_b_sr       <= w_b_sr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_start      <= w_start_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

endmodule
